// File: rtl/fetch_pc_gen.sv
// Fetch-group program counter: FETCH_W aligned lane addresses per cycle,
// with stall, group-aligned redirect with leading-lane masking, and halt.
module fetch_pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      FETCH_W   = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc_out [FETCH_W],
  output logic [FETCH_W-1:0] lane_valid,
  output logic             fetch_valid,
  output logic             halted
);

  localparam int unsigned OFF_W  = $clog2(FETCH_W * 4);
  localparam int unsigned LANE_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(FETCH_W * 4);

  if ((FETCH_W < 1) || (FETCH_W > 8) ||
      ((FETCH_W & (FETCH_W - 1)) != 0)) begin : g_bad_fw
    $error("fetch_pc_gen: FETCH_W must be a power of two in 1..8");
  end

  if ((RESET_VEC % (FETCH_W * 4)) != 0) begin : g_bad_rv
    $error("fetch_pc_gen: RESET_VEC not aligned to the fetch group");
  end

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] base;
  logic [LANE_W-1:0] start_lane;

  logic [WIDTH-1:0]  redir_base;
  logic [LANE_W-1:0] redir_lane;
  logic              unused_pc_bits;

  assign redir_base = {redirect_pc[WIDTH-1:OFF_W], OFF_W'(0)};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Word index within the group selects the first live lane.
  if (FETCH_W > 1) begin : g_lane
    assign redir_lane = redirect_pc[OFF_W-1:2];
  end else begin : g_lane1
    assign redir_lane = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= RESET_VEC;
      start_lane <= '0;
      state      <= RUN;
    end else if (redirect_valid) begin
      base       <= redir_base;
      start_lane <= redir_lane;
      state      <= RUN;
    end else if (state == HALT) begin
      state      <= HALT;
    end else if (halt_req) begin
      state      <= HALT;
    end else if (!stall_f) begin
      base       <= base + STEP;
      start_lane <= '0;
    end
  end

  for (genvar i = 0; i < FETCH_W; i++) begin : g_out
    assign pc_out[i]     = base + WIDTH'(4 * i);
    assign lane_valid[i] = (state == RUN) &&
                           (start_lane <= LANE_W'(i));
  end

  assign fetch_valid = |lane_valid;
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with FETCH_W=2, WIDTH=32, RESET_VEC=0.
// Expected lane addresses and masks are hand-computed per step.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] pc_out [2];
  logic [1:0]  lane_valid;
  logic        fetch_valid;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_gen #(
    .WIDTH(32),
    .FETCH_W(2),
    .RESET_VEC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_f(stall_f),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .pc_out(pc_out),
    .lane_valid(lane_valid),
    .fetch_valid(fetch_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grp(input string tag,
                            input logic [31:0] p0,
                            input logic [31:0] p1,
                            input logic [1:0]  lv,
                            input logic        h);
    check({tag, ".pc0"}, pc_out[0], p0);
    check({tag, ".pc1"}, pc_out[1], p1);
    check({tag, ".lv"}, 32'(lane_valid), 32'(lv));
    check({tag, ".fv"}, 32'(fetch_valid), 32'(|lv));
    check({tag, ".halt"}, 32'(halted), 32'(h));
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = 'x;
  endtask

  initial begin
    rst            = 1'b1;
    stall_f        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 'x;
    halt_req       = 1'b0;
    step();
    rst = 1'b0;
    expect_grp("reset", 32'h0, 32'h4, 2'b11, 1'b0);
    step();
    expect_grp("run1", 32'h8, 32'hC, 2'b11, 1'b0);

    stall_f = 1'b1;
    step();
    expect_grp("stall1", 32'h8, 32'hC, 2'b11, 1'b0);
    step();
    expect_grp("stall2", 32'h8, 32'hC, 2'b11, 1'b0);
    stall_f = 1'b0;
    step();
    expect_grp("run2", 32'h10, 32'h14, 2'b11, 1'b0);
    step();
    expect_grp("run3", 32'h18, 32'h1C, 2'b11, 1'b0);

    redir(32'h106);
    expect_grp("mis", 32'h100, 32'h104, 2'b10, 1'b0);
    step();
    expect_grp("mis_next", 32'h108, 32'h10C, 2'b11, 1'b0);

    // Misaligned redirect under stall keeps its mask until advance.
    stall_f = 1'b1;
    redir(32'h10C);
    expect_grp("mis_st", 32'h108, 32'h10C, 2'b10, 1'b0);
    step();
    expect_grp("mis_hold", 32'h108, 32'h10C, 2'b10, 1'b0);
    stall_f = 1'b0;
    step();
    expect_grp("mis_adv", 32'h110, 32'h114, 2'b11, 1'b0);

    redir(32'hFFFF_FFF8);
    expect_grp("top", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'b11, 1'b0);
    step();
    expect_grp("wrap", 32'h0, 32'h4, 2'b11, 1'b0);

    redir(32'h20);
    expect_grp("pre_halt", 32'h20, 32'h24, 2'b11, 1'b0);
    halt_req = 1'b1;
    stall_f  = 1'b1;
    step();
    halt_req = 1'b0;
    expect_grp("halt", 32'h20, 32'h24, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      stall_f = i[0];
      step();
      expect_grp($sformatf("halt_hold%0d", i),
                 32'h20, 32'h24, 2'b00, 1'b1);
    end
    stall_f = 1'b0;
    redir(32'h40);
    expect_grp("unhalt", 32'h40, 32'h44, 2'b11, 1'b0);

    stall_f  = 1'b1;
    halt_req = 1'b1;
    redir(32'h84);
    stall_f  = 1'b0;
    halt_req = 1'b0;
    expect_grp("redir_all", 32'h80, 32'h84, 2'b10, 1'b0);
    step();
    expect_grp("after_all", 32'h88, 32'h8C, 2'b11, 1'b0);

    // Reset wins over a simultaneous redirect, halt and stall.
    rst      = 1'b1;
    stall_f  = 1'b1;
    halt_req = 1'b1;
    redir(32'h206);
    rst      = 1'b0;
    stall_f  = 1'b0;
    halt_req = 1'b0;
    expect_grp("mid_rst", 32'h0, 32'h4, 2'b11, 1'b0);
    step();
    expect_grp("post_rst", 32'h8, 32'hC, 2'b11, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
